// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS main control FSM.
// master = control unit (drives strobes), slave = datapath (drives IR opcode and flags).
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] alu_op;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op,
               illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op,
               illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/write-back
// sequencing with registered Moore strobes; only the FETCH handshake strobes,
// pc_en and illegal_op are combined with live inputs.
module mips_multicycle_control (
    input  logic                             clk,
    input  logic                             rst_n,
    mips_multicycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Registered strobe set; fetch marks FETCH so ir_write/pc_write can be
    // qualified by mem_ready without decoding the state again.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_op;
    } ctrl_t;

    state_t r_state;
    state_t w_nxt;
    ctrl_t  r_ctrl;
    logic   w_fetch_go;
    logic   w_pc_write;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Strobes for a given state; opcode is only consulted for states entered
    // from DECODE, where the IR is already stable.
    function automatic ctrl_t state_outputs(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'd1;
            end
            S_DECODE:    c.alu_src_b = 2'd3;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 4'd8;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                case (op)
                    OP_ANDI: begin c.alu_op = 4'd5; c.ext_zero = 1'b1; end
                    OP_ORI:  begin c.alu_op = 4'd7; c.ext_zero = 1'b1; end
                    default: c.alu_op = 4'd2;
                endcase
            end
            S_I_WB:      c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 4'd1;
                c.pc_source     = 2'd1;
                c.pc_write_cond = 1'b1;
                c.branch_ne     = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state selection, including memory wait holds and opcode dispatch.
    always_comb begin
        w_nxt = S_FETCH;
        case (r_state)
            S_IDLE:      w_nxt = S_FETCH;
            S_FETCH:     w_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:             w_nxt = S_MEM_ADDR;
                    OP_RTYPE:                 w_nxt = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI: w_nxt = S_I_EXEC;
                    OP_BEQ, OP_BNE:           w_nxt = S_BRANCH;
                    OP_J:                     w_nxt = S_JUMP;
                    default:                  w_nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_nxt = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_nxt = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_nxt = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_nxt = S_R_WB;
            S_I_EXEC:    w_nxt = S_I_WB;
            default:     w_nxt = S_FETCH;
        endcase
    end

    // State register with strobes registered for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_nxt;
            r_ctrl  <= state_outputs(w_nxt, bus.opcode);
        end
    end

    assign w_fetch_go     = r_ctrl.fetch & bus.mem_ready;
    assign w_pc_write     = r_ctrl.pc_write | w_fetch_go;

    assign bus.pc_en      = w_pc_write | (r_ctrl.pc_write_cond & (bus.zero ^ r_ctrl.branch_ne));
    assign bus.ir_write   = w_fetch_go;
    assign bus.pc_source  = r_ctrl.pc_source;
    assign bus.i_or_d     = r_ctrl.i_or_d;
    assign bus.mem_read   = r_ctrl.mem_read;
    assign bus.mem_write  = r_ctrl.mem_write;
    assign bus.reg_write  = r_ctrl.reg_write;
    assign bus.reg_dst    = r_ctrl.reg_dst;
    assign bus.mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.alu_src_a  = r_ctrl.alu_src_a;
    assign bus.alu_src_b  = r_ctrl.alu_src_b;
    assign bus.ext_zero   = r_ctrl.ext_zero;
    assign bus.alu_op     = r_ctrl.alu_op;
    // The opcode is only valid once the IR has loaded, so this is decoded live.
    assign bus.illegal_op = (r_state == S_DECODE) & ~op_supported(bus.opcode);
    assign bus.state      = r_state;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle main control FSM for the 32-bit MIPS datapath. It sequences fetch, decode, execute, memory and write-back for every instruction and drives the datapath control strobes. It is the producer of the 4-bit `alu_op` code that `alu_control_unit` consumes alongside `func`. Memory accesses hold in place until the memory returns a ready handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; stable outside FETCH, since the IR loads only in FETCH.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_en`  out  1  PC load enable.
- `pc_source`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- `i_or_d`  out  1  0 = PC address, 1 = ALUOut address.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `ir_write`  out  1  IR load.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `mem_to_reg`  out  1  1 = MDR, 0 = ALUOut.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  0 = B, 1 = constant 4, 2 = extended immediate, 3 = sign-extended immediate << 2.
- `ext_zero`  out  1  1 = zero-extend the immediate.
- `alu_op`  out  4  0 = add, 1 = sub (branch), 2 = add (addi), 5 = and, 7 = or, 8 = R-type (decode by `func`).
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  4  current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- The design is Moore style: outputs decode from the state register. Exceptions are `pc_en` and the FETCH strobes gated by `mem_ready`.
- `pc_en` = `pc_write` | (`pc_write_cond` & (`zero` ^ `branch_ne`)). `pc_write`, `pc_write_cond` and `branch_ne` are internal.
- Any output not listed for a state is 0.

States (encoding) and outputs:
- IDLE (0): all outputs 0. Next state is FETCH unconditionally.
- FETCH (1):
  - Drives `mem_read`=1, `alu_src_b`=1, `alu_op`=0.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE (2): `alu_src_b`=3, `alu_op`=0 (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEM_ADDR.
  - R-type → R_EXEC.
  - addi, andi or ori → I_EXEC.
  - beq or bne → BRANCH.
  - j → JUMP.
  - Any other opcode: assert `illegal_op` and go to FETCH.
- MEM_ADDR (3): `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ (4): `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB (5): `reg_write`=1, `mem_to_reg`=1. Next state FETCH.
- MEM_WRITE (6): `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then FETCH.
- R_EXEC (7): `alu_src_a`=1, `alu_src_b`=0, `alu_op`=8. Next state R_WB.
- R_WB (8): `reg_write`=1, `reg_dst`=1. Next state FETCH.
- I_EXEC (9):
  - `alu_src_a`=1, `alu_src_b`=2.
  - `alu_op` = 2, 5 or 7 for addi, andi, ori.
  - `ext_zero`=1 for andi and ori.
  - Next state I_WB.
- I_WB (10): `reg_write`=1, `reg_dst`=0. Next state FETCH.
- BRANCH (11):
  - `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_source`=1.
  - `pc_write_cond`=1; `branch_ne`=1 for bne.
  - Next state FETCH.
- JUMP (12): `pc_write`=1, `pc_source`=2. Next state FETCH.
- Encodings 13–15 are unreachable and recover to FETCH on the next clock.

## Timing
- Reset: `rst_n`=0 forces IDLE immediately, independent of the clock.
  - All outputs read 0, and `state`=0, while `rst_n`=0.
  - An instruction in flight is abandoned. No strobe is held over.
- The first FETCH is the second rising edge after `rst_n` deasserts.
- Cycle counts with `mem_ready` tied to 1, counted FETCH through last state:
  - R-type: 4.
  - lw: 5.
  - sw: 4.
  - addi, andi, ori: 4.
  - beq, bne, j: 3.
  - Illegal opcode: 2.
- Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Strobes stay asserted, and addresses stay stable, for the whole wait.
- `mem_ready` has no effect in states that do not access memory.
- `ir_write` and `pc_write` pulse only in the single FETCH cycle where `mem_ready`=1, so the PC increments exactly once per instruction.
- `illegal_op` is high for exactly the one DECODE cycle.

## Test plan
- Reset: hold `rst_n`=0 across clocks with random inputs → all outputs 0 and `state`=0. Release → IDLE for 1 cycle, then FETCH with `mem_read`=1, `alu_src_b`=1.
- R-type, opcode 000000, `mem_ready`=1 → `state` sequence 1,2,7,8,1. `alu_op`=8 in R_EXEC; `reg_write`=1 and `reg_dst`=1 in R_WB.
- lw, opcode 100011, `mem_ready`=0 for 2 cycles in MEM_READ → sequence 1,2,3,4,4,4,5,1. `mem_read`=1 and `i_or_d`=1 throughout MEM_READ; `mem_to_reg`=1 in MEM_WB.
- Branches:
  - beq with `zero`=1 → `pc_en`=1, `pc_source`=1 in BRANCH.
  - beq with `zero`=0 → `pc_en`=0.
  - bne with `zero`=0 → `pc_en`=1.
- ori, opcode 001101 → I_EXEC with `alu_op`=7, `ext_zero`=1, `alu_src_b`=2. Then I_WB with `reg_write`=1.
- Illegal opcode 111111 → `illegal_op`=1 for one cycle in DECODE, next state FETCH, no `reg_write` or `mem_write`. Separately, assert `rst_n`=0 mid-MEM_WRITE → `mem_write` drops to 0 immediately, before the next clock edge.
